pattern_bist_ctrl: RTL and testbench
====================================

PATTERN_BIST_CTRL -- requirements
Module: pattern_bist_ctrl

Interface
REQ-001 Parameter STIM_W, default 15, SHALL set the stimulus width driven into the pattern-merge circuit under test (CUT).
REQ-002 Parameter RESP_W, default 13, SHALL set the response width captured from the CUT (RESP_W <= 16).
REQ-003 blif_clk_net  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 blif_reset_net  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 start  in  1  SHALL request a test run; sampled only in IDLE or DONE.
REQ-006 abort  in  1  SHALL cancel a run in progress.
REQ-007 seed  in  16  SHALL be the LFSR seed, loaded on an accepted start.
REQ-008 pat_count  in  16  SHALL be the number of patterns to apply, loaded on an accepted start.
REQ-009 golden  in  16  SHALL be the expected signature.
REQ-010 resp  in  RESP_W  SHALL carry the CUT outputs (combinational and registered).
REQ-011 stim  out  STIM_W  SHALL drive the CUT inputs, registered.
REQ-012 busy  out  1  SHALL be high in SEED, RUN and FLUSH.
REQ-013 done  out  1  SHALL be high in DONE.
REQ-014 signature  out  16  SHALL expose the MISR contents.
REQ-015 pass  out  1  SHALL equal (signature == golden) while done=1, else 0.

Function
REQ-016 FSM states SHALL be IDLE, SEED, RUN, FLUSH, DONE.
REQ-017 IDLE/DONE + start=1: lfsr <= seed (seed==0 replaced by 16'h0001), misr <= 0, cnt <= pat_count, next SEED; if pat_count==0, next DONE directly with signature 0.
REQ-018 SEED SHALL last one cycle, drive stim = lfsr[STIM_W-1:0], then enter RUN.
REQ-019 LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0, advancing once per RUN cycle.
REQ-020 stim SHALL update from lfsr each RUN cycle; one new pattern per cycle.
REQ-021 MISR SHALL be 16-bit, same polynomial, next = shift(misr) XOR zero-extended resp, updated every RUN and FLUSH cycle.
REQ-022 cnt SHALL decrement each RUN cycle; at cnt==1 the FSM SHALL go to FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle (captures the CUT's registered-output latency), then DONE; total MISR captures = pat_count+1.
REQ-024 DONE SHALL hold signature and stim stable until the next accepted start.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 abort=1 in SEED/RUN/FLUSH SHALL return to IDLE next cycle, stim <= 0, done never asserted; abort has priority over cnt expiry.
REQ-027 start and abort in the same IDLE cycle: abort SHALL win (start ignored).

Reset
REQ-028 Reset low SHALL immediately force state=IDLE, lfsr=16'h0001, misr=0, cnt=0, stim=0, busy=0, done=0, pass=0.
REQ-029 Reset mid-run SHALL discard the run; no done pulse after release.

Structure
REQ-030 A shared package SHALL hold the state enum, the 16-bit polynomial tap mask, and the nonzero-seed default constant.
REQ-031 One sub-module, bist_lfsr16 (parameterised shift with optional parallel XOR input), SHALL be instantiated twice: as pattern LFSR and as MISR.

Verification
REQ-032 seed=16'h0001, pat_count=1 -> SEED, 1 RUN, FLUSH, DONE; busy high exactly 3 cycles; stim shows 15'h0001 then next LFSR value.
REQ-033 pat_count=0 -> done next cycle, signature=16'h0000, pass=1 when golden=0.
REQ-034 seed=0, pat_count=4, resp tied 0 -> stim sequence identical to seed=16'h0001 run; signature=16'h0000.
REQ-035 pat_count=100 against a reference model of the CUT -> signature matches model; pass=1 with correct golden, pass=0 with golden bit 0 flipped.
REQ-036 abort asserted on RUN cycle 3 of pat_count=10 -> IDLE next cycle, stim=0, done stays 0; subsequent start runs normally.
REQ-037 reset asserted mid-RUN -> all outputs 0 asynchronously; start during RUN (no abort) -> ignored, cnt unaffected.

Source files
------------

// File: rtl/pattern_bist_ctrl_pkg.sv
// Shared types and constants for the pattern BIST controller and its shift-register blocks.
package pattern_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> taps on bits 15, 13, 12, 10
    localparam logic [15:0] POLY_TAPS    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'h0001;

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    function automatic logic [15:0] nonzero_seed(input logic [15:0] s);
        return (s == 16'h0000) ? SEED_DEFAULT : s;
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci shift register, shifting left with feedback into bit 0.
// With USE_PAR set, a parallel word is XORed into every shift, turning it into a MISR.
module bist_lfsr16
    import pattern_bist_ctrl_pkg::*;
#(
    parameter logic [15:0] TAPS    = POLY_TAPS,
    parameter logic [15:0] RST_VAL = SEED_DEFAULT,
    parameter bit          USE_PAR = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        en_i,
    input  logic [15:0] par_i,
    output logic [15:0] state_o,
    output logic [15:0] next_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] par_w;
    logic [15:0] shift_w;

    assign par_w   = USE_PAR ? par_i : 16'h0000;
    assign shift_w = {state_q[14:0], ^(state_q & TAPS)};
    assign next_o  = shift_w ^ par_w;
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            state_d = next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pattern_bist_ctrl.sv
// Pattern BIST controller: drives LFSR stimulus into a CUT, compacts its response in a MISR
// and compares the final signature against a golden value.
module pattern_bist_ctrl
    import pattern_bist_ctrl_pkg::*;
#(
    parameter int STIM_W = 15,
    parameter int RESP_W = 13
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       seed,
    input  logic [15:0]       pat_count,
    input  logic [15:0]       golden,
    input  logic [RESP_W-1:0] resp,
    output logic [STIM_W-1:0] stim,
    output logic              busy,
    output logic              done,
    output logic [15:0]       signature,
    output logic              pass
);

    bist_state_e       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [STIM_W-1:0] stim_q, stim_d;

    logic              lfsr_load, lfsr_en;
    logic              misr_clr, misr_en;
    logic [15:0]       lfsr_state, lfsr_next;
    logic [15:0]       misr_state, misr_next_unused;
    logic [15:0]       resp_ext;
    logic              bits_unused;

    always_comb begin
        resp_ext               = 16'h0000;
        resp_ext[RESP_W-1:0]   = resp;
    end

    bist_lfsr16 #(
        .TAPS    (POLY_TAPS),
        .RST_VAL (SEED_DEFAULT),
        .USE_PAR (1'b0)
    ) u_pat_lfsr (
        .clk_i      (blif_clk_net),
        .rst_ni     (blif_reset_net),
        .load_i     (lfsr_load),
        .load_val_i (nonzero_seed(seed)),
        .en_i       (lfsr_en),
        .par_i      (16'h0000),
        .state_o    (lfsr_state),
        .next_o     (lfsr_next)
    );

    bist_lfsr16 #(
        .TAPS    (POLY_TAPS),
        .RST_VAL (16'h0000),
        .USE_PAR (1'b1)
    ) u_misr (
        .clk_i      (blif_clk_net),
        .rst_ni     (blif_reset_net),
        .load_i     (misr_clr),
        .load_val_i (16'h0000),
        .en_i       (misr_en),
        .par_i      (resp_ext),
        .state_o    (misr_state),
        .next_o     (misr_next_unused)
    );

    // Only the low STIM_W pattern bits reach the CUT; the rest are intentionally dropped.
    assign bits_unused = ^{lfsr_state, lfsr_next, misr_next_unused};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stim_d    = stim_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    lfsr_load = 1'b1;
                    misr_clr  = 1'b1;
                    cnt_d     = pat_count;
                    state_d   = (pat_count == 16'h0000) ? ST_DONE : ST_SEED;
                end
            end

            ST_SEED: begin
                if (abort) begin
                    stim_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    stim_d  = lfsr_state[STIM_W-1:0];
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    stim_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    lfsr_en = 1'b1;
                    misr_en = 1'b1;
                    stim_d  = lfsr_next[STIM_W-1:0];
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            // One extra capture so a registered CUT output from the last pattern is compacted.
            ST_FLUSH: begin
                if (abort) begin
                    stim_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    misr_en = 1'b1;
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'h0000;
            stim_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = (state_q == ST_SEED) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign signature = misr_state;
    assign pass      = done && (misr_state == golden);

endmodule

// File: tb/tb_pattern_bist_ctrl.sv
// Directed bench for pattern_bist_ctrl with a small two-stage CUT model driving resp.
module tb_pattern_bist_ctrl;

    localparam int STIM_W = 15;
    localparam int RESP_W = 13;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              abort     = 1'b0;
    logic [15:0]       seed      = 16'h0000;
    logic [15:0]       pat_count = 16'h0000;
    logic [15:0]       golden    = 16'h0000;
    logic [RESP_W-1:0] resp;
    logic [STIM_W-1:0] stim;
    logic              busy;
    logic              done;
    logic [15:0]       signature;
    logic              pass;

    logic [1:0]        resp_mode  = 2'd0;
    logic [RESP_W-1:0] resp_const = 13'h0055;
    logic [STIM_W-1:0] cut_q;
    logic [RESP_W-1:0] cut_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_bist_ctrl #(
        .STIM_W (STIM_W),
        .RESP_W (RESP_W)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .pat_count      (pat_count),
        .golden         (golden),
        .resp           (resp),
        .stim           (stim),
        .busy           (busy),
        .done           (done),
        .signature      (signature),
        .pass           (pass)
    );

    // CUT: registered copy of the previous stimulus mixed with a rotated view of the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cut_q <= '0;
        else        cut_q <= stim;
    end
    assign cut_resp = cut_q[12:0] ^ {stim[7:0], stim[14:10]};

    always_comb begin
        case (resp_mode)
            2'd0:    resp = '0;
            2'd1:    resp = cut_resp;
            default: resp = resp_const;
        endcase
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] s, input logic [15:0] n);
        seed      = s;
        pat_count = n;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
        checks++; if (stim !== 15'h0000) begin errors++; $display("FAIL reset_stim: got %h want 0000", stim); end
        checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL reset_sig: got %h want 0000", signature); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        logic [STIM_W-1:0] slog [6];
        int busy_cnt;
        busy_cnt  = 0;
        resp_mode = 2'd2;
        golden    = 16'h00FF;
        start_run(16'h0001, 16'd1);
        for (int i = 0; i < 6; i++) begin
            slog[i] = stim;
            if (busy) busy_cnt++;
            step();
        end
        checks++; if (busy_cnt != 3) begin errors++; $display("FAIL single_busy_cycles: got %0d want 3", busy_cnt); end
        checks++; if (slog[1] !== 15'h0001) begin errors++; $display("FAIL single_stim0: got %h want 0001", slog[1]); end
        checks++; if (slog[2] !== 15'h0002) begin errors++; $display("FAIL single_stim1: got %h want 0002", slog[2]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
        checks++; if (signature !== 16'h00FF) begin errors++; $display("FAIL single_sig: got %h want 00ff", signature); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL single_pass: got %b want 1", pass); end
        checks++; if (stim !== 15'h0002) begin errors++; $display("FAIL single_stim_hold: got %h want 0002", stim); end
        golden = 16'h00FE;
        #1;
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL single_pass_bad_golden: got %b want 0", pass); end
    endtask

    task automatic test_zero_count();
        resp_mode = 2'd2;
        golden    = 16'h0000;
        start_run(16'h1234, 16'd0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL zero_sig: got %h want 0000", signature); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass: got %b want 1", pass); end
    endtask

    task automatic test_seed_zero();
        logic [STIM_W-1:0] e;
        resp_mode = 2'd0;
        golden    = 16'h0000;
        start_run(16'h0000, 16'd4);
        for (int k = 0; k < 5; k++) begin
            step();
            e = 15'h0001;
            e = e << k;
            checks++; if (stim !== e) begin errors++; $display("FAIL seed0_stim%0d: got %h want %h", k, stim, e); end
        end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL seed0_done: got %b want 1", done); end
        checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL seed0_sig: got %h want 0000", signature); end
    endtask

    task automatic test_start_ignored();
        resp_mode = 2'd0;
        start_run(16'h0001, 16'd5);
        step();
        step();
        start     = 1'b1;
        pat_count = 16'd50;
        seed      = 16'hFFFF;
        step();
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL busy_start_flush: got busy=%b done=%b want 1/0", busy, done); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done: got %b want 1", done); end
        checks++; if (stim !== 15'h0020) begin errors++; $display("FAIL busy_start_stim: got %h want 0020", stim); end
    endtask

    task automatic test_abort();
        bit seen_done;
        resp_mode = 2'd0;
        start_run(16'h0001, 16'd10);
        step();
        step();
        step();
        checks++; if (busy !== 1'b1 || stim !== 15'h0004) begin errors++; $display("FAIL abort_pre: got busy=%b stim=%h want 1/0004", busy, stim); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (stim !== 15'h0000) begin errors++; $display("FAIL abort_stim: got %h want 0000", stim); end
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", seen_done); end
        start_run(16'h0001, 16'd2);
        step();
        step();
        step();
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_rerun_done: got %b want 1", done); end
        checks++; if (stim !== 15'h0004) begin errors++; $display("FAIL abort_rerun_stim: got %h want 0004", stim); end
    endtask

    task automatic test_abort_start_same();
        start_run(16'h0001, 16'd10);
        abort = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_to_idle: got busy=%b want 0", busy); end
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL same_cycle: got busy=%b done=%b want 0/0", busy, done); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_cycle_late: got busy=%b want 0", busy); end
    endtask

    task automatic test_long();
        logic [15:0]       v, m, exp_sig;
        logic [STIM_W-1:0] s, prev;
        logic [RESP_W-1:0] r;
        int                cnt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        v    = 16'hACE1;
        m    = 16'h0000;
        prev = '0;
        for (int j = 0; j <= 100; j++) begin
            s    = v[14:0];
            r    = prev[12:0] ^ {s[7:0], s[14:10]};
            m    = lfsr_step(m) ^ {3'b000, r};
            prev = s;
            v    = lfsr_step(v);
        end
        exp_sig   = m;
        golden    = exp_sig;
        resp_mode = 2'd1;
        start_run(16'hACE1, 16'd100);
        cnt = 1;
        while (!done && cnt < 300) begin
            step();
            cnt++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL long_timeout: got done=%b after %0d cycles want 1", done, cnt); end
        checks++; if (cnt != 103) begin errors++; $display("FAIL long_latency: got %0d want 103", cnt); end
        checks++; if (signature !== exp_sig) begin errors++; $display("FAIL long_sig: got %h want %h", signature, exp_sig); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL long_pass: got %b want 1", pass); end
        golden = exp_sig ^ 16'h0001;
        #1;
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL long_pass_flip: got %b want 0", pass); end
    endtask

    task automatic test_reset_midrun();
        bit seen;
        resp_mode = 2'd1;
        golden    = 16'h0000;
        start_run(16'h0001, 16'd20);
        step();
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL midrst_pass: got %b want 0", pass); end
        checks++; if (stim !== 15'h0000) begin errors++; $display("FAIL midrst_stim: got %h want 0000", stim); end
        checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL midrst_sig: got %h want 0000", signature); end
        #2;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_count();
        test_seed_zero();
        test_start_ignored();
        test_abort();
        test_abort_start_same();
        test_long();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
